ascii_to_ps2_tx: RTL

//  Inverse of the PS/2-to-ASCII decode: accepts one ASCII character per handshake and maps it to a
//  PS/2 set-2 scancode. Serialises make + break (F0, code) as device-side PS/2 frames on ps2_clk/ps2_data.

---
 rtl/ascii_to_ps2_tx_if.sv | 9 +
 rtl/ascii_to_ps2_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ascii_to_ps2_tx_if.sv
// Character handshake between a text producer and the PS/2 keyboard emulator.
interface ascii_to_ps2_tx_if;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;

  modport master (output ascii_in, output ascii_valid, input ascii_ready);
  modport slave  (input ascii_in, input ascii_valid, output ascii_ready);
endinterface

// File: rtl/ascii_to_ps2_tx.sv
// Keyboard emulator: maps one ASCII character to a set-2 scancode and sends make + break
// (code, F0, code) as device-side PS/2 frames.
module ascii_to_ps2_tx #(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 5000
) (
  input  logic                     clock,
  input  logic                     resetn,
  ascii_to_ps2_tx_if.slave         req,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic                     unmapped
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBitHi, StBitLo, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      code_q, code_d;
  logic            mapped_q, mapped_d;
  // Accepted character waiting for its dispatch cycle
  logic            pend_q, pend_d;
  logic            ready_q, ready_d;
  logic            clk_q, clk_d;
  logic            data_q, data_d;
  logic            busy_q, busy_d;
  logic            unm_q, unm_d;
  logic [7:0]      cur_byte;

  // Returns {mapped, scancode}; lower-case letters fold onto upper case.
  function automatic logic [8:0] map_code(input logic [7:0] c);
    logic [7:0] f;
    f = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (f)
      8'h41: map_code = {1'b1, 8'h1C};  8'h42: map_code = {1'b1, 8'h32};
      8'h43: map_code = {1'b1, 8'h21};  8'h44: map_code = {1'b1, 8'h23};
      8'h45: map_code = {1'b1, 8'h24};  8'h46: map_code = {1'b1, 8'h2B};
      8'h47: map_code = {1'b1, 8'h34};  8'h48: map_code = {1'b1, 8'h33};
      8'h49: map_code = {1'b1, 8'h43};  8'h4A: map_code = {1'b1, 8'h3B};
      8'h4B: map_code = {1'b1, 8'h42};  8'h4C: map_code = {1'b1, 8'h4B};
      8'h4D: map_code = {1'b1, 8'h3A};  8'h4E: map_code = {1'b1, 8'h31};
      8'h4F: map_code = {1'b1, 8'h44};  8'h50: map_code = {1'b1, 8'h4D};
      8'h51: map_code = {1'b1, 8'h15};  8'h52: map_code = {1'b1, 8'h2D};
      8'h53: map_code = {1'b1, 8'h1B};  8'h54: map_code = {1'b1, 8'h2C};
      8'h55: map_code = {1'b1, 8'h3C};  8'h56: map_code = {1'b1, 8'h2A};
      8'h57: map_code = {1'b1, 8'h1D};  8'h58: map_code = {1'b1, 8'h22};
      8'h59: map_code = {1'b1, 8'h35};  8'h5A: map_code = {1'b1, 8'h1A};
      8'h20: map_code = {1'b1, 8'h29};
      default: map_code = 9'h000;
    endcase
  endfunction

  // Bit n of an 11-bit frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
    if (n == 4'd0)       frame_bit = 1'b0;
    else if (n <= 4'd8)  frame_bit = b[3'(n - 4'd1)];
    else if (n == 4'd9)  frame_bit = ~^b;
    else                 frame_bit = 1'b1;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      mapped_q <= 1'b0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b1;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      busy_q   <= 1'b0;
      unm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      mapped_q <= mapped_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      unm_q    <= unm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    code_d   = code_q;
    mapped_d = mapped_q;
    pend_d   = pend_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (mapped_q) begin
            state_d = StBitHi;
            cnt_d   = '0;
            bit_d   = '0;
            idx_d   = '0;
          end
        end else if (req.ascii_valid && ready_q) begin
          pend_d             = 1'b1;
          {mapped_d, code_d} = map_code(req.ascii_in);
        end
      end
      StBitHi: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = StBitLo;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBitLo: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            state_d = StGap;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = StBitHi;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == 2'd2) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 2'd1;
            bit_d   = '0;
            state_d = StBitHi;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so the registered lines change with it.
  always_comb begin
    cur_byte = (idx_d == 2'd1) ? 8'hF0 : code_d;
    ready_d  = (state_d == StIdle) && !pend_d;
    busy_d   = !ready_d;
    unm_d    = (state_q == StIdle) && pend_q && !mapped_q;
    clk_d    = (state_d != StBitLo);
    data_d   = 1'b1;
    if (state_d == StBitHi || state_d == StBitLo) data_d = frame_bit(cur_byte, bit_d);
  end

  assign req.ascii_ready = ready_q;
  assign ps2_clk         = clk_q;
  assign ps2_data        = data_q;
  assign busy            = busy_q;
  assign unmapped        = unm_q;

endmodule
